// File: rtl/pixel_pkg.sv
// Shared constants for the 8-bit grayscale point-operator pipeline.
// Operation codes and pixel range limits.
package pixel_pkg;

  localparam logic [0:1] OP_BRIGHTEN = 2'd0;
  localparam logic [0:1] OP_DARKEN   = 2'd1;
  localparam logic [0:1] OP_THRESH   = 2'd2;
  localparam logic [0:1] OP_INVERT   = 2'd3;

  localparam logic [0:7] PIX_MAX = 8'hFF;
  localparam logic [0:7] PIX_MIN = 8'h00;

endpackage

// File: rtl/pixel_operator_if.sv
// Pixel stream bundle between image reader, operator and writer.
// No handshake: one pixel per clock.
interface pixel_operator_if #(
  parameter int DATA_W = 8
);

  logic [0:DATA_W-1] inbyte;
  logic [0:DATA_W-1] threshold;
  logic [0:DATA_W-1] value;
  logic [0:1]        select;
  logic [0:DATA_W-1] outbyte;

  modport master (
    output inbyte,
    output threshold,
    output value,
    output select,
    input  outbyte
  );

  modport slave (
    input  inbyte,
    input  threshold,
    input  value,
    input  select,
    output outbyte
  );

endinterface

// File: rtl/pixel_alu.sv
// Combinational point operator: brighten/darken (saturating),
// threshold and invert, selected by op code.
module pixel_alu
  import pixel_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [0:DATA_W-1] inbyte,
  input  logic [0:DATA_W-1] threshold,
  input  logic [0:DATA_W-1] value,
  input  logic [0:1]        select,
  output logic [0:DATA_W-1] result
);

  logic [0:DATA_W]   sum;
  logic [0:DATA_W-1] bright;
  logic [0:DATA_W-1] dark;
  logic [0:DATA_W-1] thresh;
  logic [0:DATA_W-1] invert;

  // Bit 0 of the widened sum is the carry out.
  assign sum    = {1'b0, inbyte} + {1'b0, value};
  assign bright = sum[0] ? {DATA_W{1'b1}} : sum[1:DATA_W];
  assign dark   = (inbyte < value) ? {DATA_W{1'b0}}
                                   : inbyte - value;
  assign thresh = (inbyte >= threshold) ? {DATA_W{1'b1}}
                                        : {DATA_W{1'b0}};
  assign invert = ~inbyte;

  always_comb begin
    result = inbyte;
    case (select)
      OP_BRIGHTEN: result = bright;
      OP_DARKEN:   result = dark;
      OP_THRESH:   result = thresh;
      OP_INVERT:   result = invert;
      default:     result = inbyte;
    endcase
  end

endmodule

// File: rtl/pixel_operator.sv
// Registered per-pixel point operator, one pixel per clock,
// one cycle latency, synchronous active-high reset.
module pixel_operator
  import pixel_pkg::*;
#(
  parameter int DATA_W = 8
) (
  output logic [0:DATA_W-1] outbyte,
  input  logic [0:DATA_W-1] inbyte,
  input  logic [0:DATA_W-1] threshold,
  input  logic [0:DATA_W-1] value,
  input  logic [0:1]        select,
  input  logic              clk,
  input  logic              rst
);

  logic [0:DATA_W-1] result;

  pixel_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .inbyte    (inbyte),
    .threshold (threshold),
    .value     (value),
    .select    (select),
    .result    (result)
  );

  always_ff @(posedge clk) begin
    if (rst)
      outbyte <= {DATA_W{1'b0}};
    else
      outbyte <= result;
  end

endmodule

// File: tb/tb_pixel_operator.sv
// Randomized check of pixel_operator against an arithmetic
// reference model, plus directed boundary cases.
module tb_pixel_operator;

  localparam int N_PIX = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pixel_operator_if #(.DATA_W(8)) bus ();

  pixel_operator #(.DATA_W(8)) dut (
    .outbyte   (bus.outbyte),
    .inbyte    (bus.inbyte),
    .threshold (bus.threshold),
    .value     (bus.value),
    .select    (bus.select),
    .clk       (clk),
    .rst       (rst)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input int s, input int px,
                                        input int thr, input int val);
    int r;
    case (s)
      0: begin r = px + val; if (r > 255) r = 255; end
      1: begin r = px - val; if (r < 0) r = 0; end
      2: r = (px >= thr) ? 255 : 0;
      default: r = 255 - px;
    endcase
    return 8'(r);
  endfunction

  task automatic drive(input logic [1:0] s, input logic [7:0] px,
                       input logic [7:0] thr, input logic [7:0] val);
    bus.select    = s;
    bus.inbyte    = px;
    bus.threshold = thr;
    bus.value     = val;
  endtask

  // Drive at a negedge, let one posedge capture, sample at the next negedge.
  task automatic op(input string tag, input logic [1:0] s,
                    input logic [7:0] px, input logic [7:0] thr,
                    input logic [7:0] val, input logic [7:0] exp);
    drive(s, px, thr, val);
    @(negedge clk);
    check(tag, bus.outbyte, exp);
  endtask

  function automatic logic [7:0] rnd_px();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] px, thr, val;
    logic [7:0] exp;

    rst = 1'b1;
    drive(2'd0, 8'hAB, 8'h00, 8'h00);
    @(negedge clk);
    check("reset0", bus.outbyte, 8'h00);
    @(negedge clk);
    check("reset1", bus.outbyte, 8'h00);
    rst = 1'b0;

    op("inv_00", 2'd3, 8'h00, 8'd160, 8'd60, 8'hFF);
    op("inv_3C", 2'd3, 8'h3C, 8'd160, 8'd60, 8'hC3);
    op("inv_A0", 2'd3, 8'hA0, 8'd160, 8'd60, 8'h5F);
    op("inv_FF", 2'd3, 8'hFF, 8'd160, 8'd60, 8'h00);

    op("brt_10", 2'd0, 8'h10, 8'd0, 8'd60, 8'h4C);
    op("brt_C3", 2'd0, 8'hC3, 8'd0, 8'd60, 8'hFF);
    op("brt_FF", 2'd0, 8'hFF, 8'd0, 8'd60, 8'hFF);
    op("brt_FF0", 2'd0, 8'hFF, 8'd0, 8'd0, 8'hFF);
    op("brt_C8", 2'd0, 8'd200, 8'd0, 8'd60, 8'hFF);
    op("brt_0FF", 2'd0, 8'h00, 8'd0, 8'hFF, 8'hFF);

    op("drk_3C", 2'd1, 8'h3C, 8'd0, 8'd60, 8'h00);
    op("drk_3B", 2'd1, 8'h3B, 8'd0, 8'd60, 8'h00);
    op("drk_FF", 2'd1, 8'hFF, 8'd0, 8'd60, 8'hC3);
    op("drk_00", 2'd1, 8'h00, 8'd0, 8'd0, 8'h00);
    op("drk_0A", 2'd1, 8'd10, 8'd0, 8'd60, 8'h00);

    op("thr_9F", 2'd2, 8'h9F, 8'd160, 8'd0, 8'h00);
    op("thr_A0", 2'd2, 8'hA0, 8'd160, 8'd0, 8'hFF);
    op("thr_A1", 2'd2, 8'hA1, 8'd160, 8'd0, 8'hFF);
    op("thr_z00", 2'd2, 8'h00, 8'h00, 8'd0, 8'hFF);
    op("thr_mFE", 2'd2, 8'hFE, 8'hFF, 8'd0, 8'h00);
    op("thr_mFF", 2'd2, 8'hFF, 8'hFF, 8'd0, 8'hFF);

    // Outbyte must hold between edges.
    drive(2'd3, 8'h12, 8'h00, 8'h00);
    @(posedge clk);
    #3;
    drive(2'd3, 8'h34, 8'h00, 8'h00);
    #3;
    check("hold", bus.outbyte, 8'hED);
    @(negedge clk);

    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < N_PIX; i++) begin
        px  = rnd_px();
        thr = rnd_px();
        val = rnd_px();
        if (i == 700) begin
          rst = 1'b1;
          drive(2'(s), px, thr, val);
          @(negedge clk);
          check("mid_rst", bus.outbyte, 8'h00);
          rst = 1'b0;
        end else begin
          exp = ref_op(s, px, thr, val);
          op("stream", 2'(s), px, thr, val, exp);
        end
      end
    end

    // Operation switches every pixel.
    for (int i = 0; i < 2000; i++) begin
      int s;
      s   = $urandom_range(0, 3);
      px  = rnd_px();
      thr = rnd_px();
      val = rnd_px();
      op("mixed", 2'(s), px, thr, val, ref_op(s, px, thr, val));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
